// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among num_req requesters.
// A grant lasts up to max_burst beats and is handed on in the same cycle it
// ends, so back-to-back grants have no idle bubble. Data passes straight
// through from the holder's slice to fifo_data_in with no added latency.
// Optional feature: define FIFO_WR_ARB_STATS_EN to add saturating per-requester
// beat counters (stat_beats) and a stall-cycle counter (stat_stall).
module fifo_wr_arbiter #(
   parameter int data_width = 8,
   parameter int num_req    = 4,
   parameter int max_burst  = 4
) (
   input  logic                            wr_clk,
   input  logic                            wr_rst,
   input  logic [num_req-1:0]              req_valid,
   input  logic [num_req*data_width-1:0]   req_data,
   output logic [num_req-1:0]              req_ready,
   output logic [data_width-1:0]           fifo_data_in,
   output logic                            fifo_wr_en,
   input  logic                            fifo_full,
   output logic [$clog2(num_req)-1:0]      grant_id,
   output logic                            busy
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [num_req*16-1:0]           stat_beats,
   output logic [15:0]                     stat_stall
`endif
);

   localparam int IDW = $clog2(num_req);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                state, state_n;
   logic [IDW-1:0]        grant_n;
   logic [IDW-1:0]        rr_ptr, rr_n, rr_inc;
   logic [7:0]            beat_cnt, beat_n;
   logic                  burst_done, release_g;
   logic [data_width-1:0] req_word [num_req];

   for (genvar i = 0; i < num_req; i++) begin : g_unpack
      assign req_word[i] = req_data[i*data_width +: data_width];
   end

   // First requester with valid set, searching from start upward with wrap.
   function automatic logic [IDW-1:0] pick(input logic [num_req-1:0] v,
                                           input logic [IDW-1:0]     start);
      logic [IDW-1:0] r;
      int             idx;
      r = start;
      for (int k = num_req - 1; k >= 0; k--) begin
         idx = (int'(start) + k) % num_req;
         if (v[IDW'(idx)]) r = IDW'(idx);
      end
      return r;
   endfunction

   // Port-facing outputs; everything is forced quiet while reset is held.
   always_comb begin
      req_ready    = '0;
      fifo_wr_en   = 1'b0;
      fifo_data_in = '0;
      busy         = 1'b0;
      if (state == GRANT && !wr_rst) begin
         busy                = 1'b1;
         req_ready[grant_id] = !fifo_full;
         fifo_wr_en          = req_valid[grant_id] && !fifo_full;
         if (fifo_wr_en) fifo_data_in = req_word[grant_id];
      end
   end

   // Next-state: grant on request in IDLE, release/re-arbitrate in GRANT.
   always_comb begin
      state_n    = state;
      grant_n    = grant_id;
      rr_n       = rr_ptr;
      beat_n     = beat_cnt;
      rr_inc     = (grant_id == IDW'(num_req - 1)) ? '0 : grant_id + 1'b1;
      burst_done = fifo_wr_en && (({1'b0, beat_cnt} + 9'd1) == 9'(max_burst));
      // A dropped valid only counts once the FIFO can accept again.
      release_g  = burst_done || (!req_valid[grant_id] && !fifo_full);
      case (state)
         IDLE: begin
            if (|req_valid) begin
               state_n = GRANT;
               grant_n = pick(req_valid, rr_ptr);
               beat_n  = '0;
            end
         end
         GRANT: begin
            if (release_g) begin
               rr_n   = rr_inc;
               beat_n = '0;
               if (|req_valid) grant_n = pick(req_valid, rr_inc);
               else            state_n = IDLE;
            end else if (fifo_wr_en) begin
               beat_n = beat_cnt + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State register; reset abandons any burst in progress.
   always_ff @(posedge wr_clk) begin
      if (wr_rst) begin
         state    <= IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_n;
         grant_id <= grant_n;
         rr_ptr   <= rr_n;
         beat_cnt <= beat_n;
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   // Saturating counters of accepted beats per requester and of stalled grant cycles.
   always_ff @(posedge wr_clk) begin
      if (wr_rst) begin
         stat_beats <= '0;
         stat_stall <= '0;
      end else begin
         for (int i = 0; i < num_req; i++) begin
            if (fifo_wr_en && grant_id == IDW'(i) && stat_beats[i*16 +: 16] != 16'hFFFF)
               stat_beats[i*16 +: 16] <= stat_beats[i*16 +: 16] + 16'd1;
         end
         if (state == GRANT && fifo_full && req_valid[grant_id] && stat_stall != 16'hFFFF)
            stat_stall <= stat_stall + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic [DW-1:0] fifo_data_in;
   logic          fifo_wr_en;
   logic          fifo_full;
   logic [1:0]    grant_id;
   logic          busy;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [N*16-1:0] stat_beats;
   logic [15:0]     stat_stall;
`endif

   fifo_wr_arbiter #(.data_width(DW), .num_req(N), .max_burst(MB)) dut (
      .wr_clk(clk), .wr_rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_data_in(fifo_data_in), .fifo_wr_en(fifo_wr_en),
      .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy)
`ifdef FIFO_WR_ARB_STATS_EN
      , .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Requester behaviour: remaining words, word sequence, data base, valid gate
   int rem[N], seq[N], base[N];
   bit gate[N];

   // Behavioural model: who holds the port (-1 none), where the search starts
   int m_hold = -1, m_ptr = 0, m_cnt = 0, m_gid = 0;
   int m_beats[N];
   int m_stall = 0;

   logic [31:0] log_wr[$], log_data[$], log_busy[$], log_gid[$], log_ready[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int first_from(input logic [N-1:0] v, input int s);
      for (int k = 0; k < N; k++) if (v[(s + k) % N]) return (s + k) % N;
      return -1;
   endfunction

   function automatic logic [DW-1:0] word_of(input int i);
      return DW'(base[i] + seq[i]);
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = (rem[i] > 0) && gate[i];
         req_data[i*DW +: DW]  = word_of(i);
      end
   endtask

   task automatic clear_logs();
      log_wr = {}; log_data = {}; log_busy = {}; log_gid = {}; log_ready = {};
   endtask

   // One clock: drive, compare at negedge, advance model, move past posedge.
   task automatic step();
      logic [N-1:0]  v, e_ready;
      logic          e_wr, e_busy;
      logic [DW-1:0] e_data;
      int            f, h;
      drive_inputs();
      @(negedge clk);
      v = req_valid;
      e_ready = '0; e_wr = 1'b0; e_busy = 1'b0; e_data = '0;
      if (!rst && m_hold >= 0) begin
         e_busy          = 1'b1;
         e_ready[m_hold] = !fifo_full;
         e_wr            = v[m_hold] && !fifo_full;
         if (e_wr) e_data = word_of(m_hold);
      end
      chk("req_ready", req_ready, e_ready);
      chk("fifo_wr_en", fifo_wr_en, e_wr);
      chk("fifo_data_in", fifo_data_in, e_data);
      chk("busy", busy, e_busy);
      chk("grant_id", grant_id, m_gid);
`ifdef FIFO_WR_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("stat_beats", stat_beats[i*16 +: 16], m_beats[i]);
      chk("stat_stall", stat_stall, m_stall);
`endif
      log_wr.push_back(fifo_wr_en);
      log_data.push_back(fifo_data_in);
      log_busy.push_back(busy);
      log_gid.push_back(grant_id);
      log_ready.push_back(req_ready);
      if (rst) begin
         m_hold = -1; m_ptr = 0; m_cnt = 0; m_gid = 0; m_stall = 0;
         for (int i = 0; i < N; i++) m_beats[i] = 0;
      end else if (m_hold < 0) begin
         f = first_from(v, m_ptr);
         if (f >= 0) begin m_hold = f; m_gid = f; m_cnt = 0; end
      end else begin
         h = m_hold;
         if (e_wr) begin
            m_cnt++;
            if (m_beats[h] < 65535) m_beats[h]++;
            rem[h]--; seq[h]++;
         end
         if (fifo_full && v[h] && m_stall < 65535) m_stall++;
         if ((e_wr && m_cnt == MB) || (!v[h] && !fifo_full)) begin
            m_ptr = (h + 1) % N;
            m_cnt = 0;
            f = first_from(v, m_ptr);
            if (f >= 0) begin m_hold = f; m_gid = f; end
            else m_hold = -1;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; base[i] = 0; gate[i] = 1'b1; end
      fifo_full = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_logs();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_wr1[9] = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
      int exp_wr3[11] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
      rst = 1'b1;
      fifo_full = 1'b0;
      for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; base[i] = 0; gate[i] = 1'b1; end
      drive_inputs();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Reset state
      drive_inputs(); #1;
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_data", fifo_data_in, 0);

      // Single requester 2, six words A0..A5
      rem[2] = 6; base[2] = 8'hA0;
      repeat (9) step();
      for (int k = 0; k < 9; k++) chk("s1_wr_en", log_wr[k], exp_wr1[k]);
      for (int k = 1; k <= 6; k++) chk("s1_data", log_data[k], 8'hA0 + k - 1);
      chk("s1_gid_first", log_gid[1], 2);
      chk("s1_gid_regrant", log_gid[5], 2);
      chk("s1_busy_release", log_busy[7], 1);
      chk("s1_busy_idle", log_busy[8], 0);

      // All four requesters continuously valid
      do_reset();
      for (int i = 0; i < N; i++) begin rem[i] = 100; base[i] = i * 16; end
      repeat (21) step();
      for (int i = 0; i < N; i++) rem[i] = 0;
      step();
      chk("s2_idle_first", log_wr[0], 0);
      for (int k = 1; k <= 20; k++) begin
         chk("s2_wr_en", log_wr[k], 1);
         chk("s2_gid", log_gid[k], ((k - 1) / 4) % 4);
      end
`ifdef FIFO_WR_ARB_STATS_EN
      chk("s2_stat0", stat_beats[15:0], 8);
      chk("s2_stat1", stat_beats[31:16], 4);
      chk("s2_stat2", stat_beats[47:32], 4);
      chk("s2_stat3", stat_beats[63:48], 4);
      chk("s2_stall", stat_stall, 0);
      do_reset();
      chk("s2_stat_clr", stat_beats, 0);
      chk("s2_stall_clr", stat_stall, 0);
`endif

      // Stall after two beats of requester 1
      do_reset();
      rem[1] = 4; base[1] = 8'h10;
      rem[2] = 4; base[2] = 8'h20;
      for (int k = 0; k < 11; k++) begin
         fifo_full = (k >= 3 && k <= 7);
         step();
      end
      for (int k = 0; k < 11; k++) chk("s3_wr_en", log_wr[k], exp_wr3[k]);
      chk("s3_ready_stall", log_ready[5], 0);
      chk("s3_gid_stall", log_gid[5], 1);
      chk("s3_data_beat4", log_data[9], 8'h13);
      chk("s3_gid_next", log_gid[10], 2);
      chk("s3_data_next", log_data[10], 8'h20);
`ifdef FIFO_WR_ARB_STATS_EN
      chk("s3_stall_cnt", stat_stall, 5);
`endif

      // Requester 3 drops valid after one beat, requester 0 waiting
      do_reset();
      rem[3] = 1; base[3] = 8'h30;
      step();
      rem[0] = 3; base[0] = 8'h40;
      repeat (3) step();
      chk("s4_beat3", log_data[1], 8'h30);
      chk("s4_drop_wr", log_wr[2], 0);
      chk("s4_drop_busy", log_busy[2], 1);
      chk("s4_drop_gid", log_gid[2], 3);
      chk("s4_handoff_gid", log_gid[3], 0);
      chk("s4_handoff_data", log_data[3], 8'h40);

      // Reset in the middle of requester 1's burst
      do_reset();
      rem[1] = 10; base[1] = 8'h50;
      rem[2] = 10; base[2] = 8'h60;
      step(); step();
      rst = 1'b1; step(); rst = 1'b0;
      step(); step();
      chk("s5_beat1", log_data[1], 8'h50);
      chk("s5_rst_wr", log_wr[2], 0);
      chk("s5_after_busy", log_busy[3], 0);
      chk("s5_after_gid", log_gid[3], 0);
      chk("s5_after_ready", log_ready[3], 0);
      chk("s5_regrant_gid", log_gid[4], 1);
      chk("s5_regrant_data", log_data[4], 8'h51);

      // Randomized traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         fifo_full = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < N; i++) begin
            if (rem[i] == 0 && $urandom_range(0, 7) == 0) begin
               rem[i] = $urandom_range(1, 10);
               base[i] = $urandom_range(0, 255);
               seq[i] = 0;
            end
            gate[i] = ($urandom_range(0, 7) != 0);
         end
         step();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
